// File: rtl/noc_xbar_reg.sv
// Output-registered NoC crossbar: each output captures the flit from its selected
// input into a one-entry register, pops the source queue, and honours downstream ready.
module noc_xbar_reg #(
  parameter int NUM_PORTS = 5,
  parameter int DATA_W    = 16,
  parameter int SEL_W     = $clog2(NUM_PORTS)
) (
  input  logic                          clk_i,
  input  logic                          rst_n_i,
  input  logic [NUM_PORTS*DATA_W-1:0]   in_data_i,
  input  logic [NUM_PORTS-1:0]          grant_i,
  input  logic [NUM_PORTS*SEL_W-1:0]    sel_i,
  input  logic [NUM_PORTS-1:0]          out_ready_i,
  output logic [NUM_PORTS-1:0]          pop_o,
  output logic [NUM_PORTS*DATA_W-1:0]   out_data_o,
  output logic [NUM_PORTS-1:0]          out_valid_o,
  output logic                          sel_err_o,
  output logic                          conflict_o
);

  // One extra bit so the limit is representable even when NUM_PORTS is a power of two.
  localparam logic [SEL_W:0] PORT_LIMIT = (SEL_W+1)'(NUM_PORTS);

  logic [SEL_W-1:0]  sel       [NUM_PORTS];
  logic [DATA_W-1:0] in_flit   [NUM_PORTS];
  logic [DATA_W-1:0] next_flit [NUM_PORTS];
  logic [DATA_W-1:0] out_reg   [NUM_PORTS];

  logic [NUM_PORTS-1:0] in_range, slot_free, req, winner, load, lost;
  logic [NUM_PORTS-1:0] out_valid_q;
  logic                 sel_err_q, conflict_q, any_bad_sel;

  genvar g;
  generate
    for (g = 0; g < NUM_PORTS; g++) begin : g_unpack
      assign sel[g]     = sel_i[g*SEL_W +: SEL_W];
      assign in_flit[g] = in_data_i[g*DATA_W +: DATA_W];
      assign out_data_o[g*DATA_W +: DATA_W] = out_reg[g];
    end
  endgenerate

  always_comb begin
    in_range  = '0;
    slot_free = '0;
    req       = '0;
    winner    = '0;
    for (int o = 0; o < NUM_PORTS; o++) begin
      in_range[o]  = {1'b0, sel[o]} < PORT_LIMIT;
      slot_free[o] = !out_valid_q[o] | out_ready_i[o];
      req[o]       = grant_i[o] & in_range[o] & slot_free[o];
    end
    // Lowest-index requester of a given input wins; higher ones must be retried.
    for (int o = 0; o < NUM_PORTS; o++) begin
      winner[o] = 1'b1;
      for (int p = 0; p < NUM_PORTS; p++) begin
        if (p < o && req[p] && sel[p] == sel[o]) winner[o] = 1'b0;
      end
    end
  end

  assign load        = req & winner & {NUM_PORTS{rst_n_i}};
  assign lost        = req & ~winner;
  assign any_bad_sel = |(grant_i & ~in_range);

  always_comb begin
    pop_o = '0;
    for (int o = 0; o < NUM_PORTS; o++) begin
      next_flit[o] = '0;
      for (int i = 0; i < NUM_PORTS; i++) begin
        if (sel[o] == SEL_W'(i)) begin
          next_flit[o] = in_flit[i];
          if (load[o]) pop_o[i] = 1'b1;
        end
      end
    end
  end

  // A consumed flit can be replaced in the same edge, so loading takes priority over draining.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int o = 0; o < NUM_PORTS; o++) out_reg[o] <= '0;
      out_valid_q <= '0;
      sel_err_q   <= 1'b0;
      conflict_q  <= 1'b0;
    end else begin
      for (int o = 0; o < NUM_PORTS; o++) begin
        if (load[o]) begin
          out_reg[o]     <= next_flit[o];
          out_valid_q[o] <= 1'b1;
        end else if (out_ready_i[o]) begin
          out_valid_q[o] <= 1'b0;
        end
      end
      sel_err_q  <= sel_err_q | any_bad_sel;
      conflict_q <= |lost;
    end
  end

  assign out_valid_o = out_valid_q;
  assign sel_err_o   = sel_err_q;
  assign conflict_o  = conflict_q;

endmodule
